ahb_reg_slice: RTL

AHB_REG_SLICE -- requirements
Module: ahb_reg_slice

---
 rtl/ahb_reg_slice.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ahb_reg_slice.sv
// AHB-Lite register slice that breaks every slave->master path and reissues each beat
// downstream as a single NONSEQ transfer.
module ahb_reg_slice #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned HPROT_WIDTH = 7
) (
  input  logic                   hclk,
  input  logic                   hreset,
  // upstream (slave-side) request
  input  logic                   slave_hsel,
  input  logic                   slave_hready_in,
  input  logic [ADDR_WIDTH-1:0]  slave_haddr,
  input  logic [1:0]             slave_htrans,
  input  logic                   slave_hwrite,
  input  logic [DATA_WIDTH-1:0]  slave_hwdata,
  input  logic [2:0]             slave_hburst,
  input  logic                   slave_hmastlock,
  input  logic [HPROT_WIDTH-1:0] slave_hprot,
  input  logic [2:0]             slave_hsize,
  input  logic                   slave_hnonsec,
  input  logic                   slave_hexcl,
  input  logic [3:0]             slave_hmaster,
  // upstream response
  output logic [DATA_WIDTH-1:0]  slave_hrdata,
  output logic                   slave_hready,
  output logic                   slave_hresp,
  output logic                   slave_hexokay,
  // downstream (master-side) request
  output logic [ADDR_WIDTH-1:0]  master_haddr,
  output logic [1:0]             master_htrans,
  output logic                   master_hwrite,
  output logic [DATA_WIDTH-1:0]  master_hwdata,
  output logic [2:0]             master_hburst,
  output logic                   master_hmastlock,
  output logic [HPROT_WIDTH-1:0] master_hprot,
  output logic [2:0]             master_hsize,
  output logic                   master_hnonsec,
  output logic                   master_hexcl,
  output logic [3:0]             master_hmaster,
  // downstream response
  input  logic [DATA_WIDTH-1:0]  master_hrdata,
  input  logic                   master_hready,
  input  logic                   master_hresp,
  input  logic                   master_hexokay
);

  typedef enum logic [2:0] {StIdle, StAddr, StData, StResp, StErr1, StErr2} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   write_q;
  logic [2:0]             size_q;
  logic [HPROT_WIDTH-1:0] prot_q;
  logic                   mastlock_q;
  logic                   nonsec_q;
  logic                   excl_q;
  logic [3:0]             master_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   exokay_q;
  logic                   accept;
  logic                   data_ok;

  // Burst type and the SEQ/NONSEQ distinction are dropped: every beat goes out as SINGLE.
  logic unused_inputs;
  assign unused_inputs = ^{slave_hburst, slave_htrans[0]};

  assign slave_hready = (state_q == StIdle) || (state_q == StResp) || (state_q == StErr2);
  assign accept       = slave_hsel & slave_hready_in & slave_htrans[1] & slave_hready;
  assign data_ok      = (state_q == StData) & master_hready & ~master_hresp;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StResp, StErr2: state_d = accept ? StAddr : StIdle;
      StAddr:                 if (master_hready) state_d = StData;
      StData:                 if (master_hready) state_d = master_hresp ? StErr1 : StResp;
      StErr1:                 state_d = StErr2;
      default:                state_d = StIdle;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      write_q    <= 1'b0;
      size_q     <= '0;
      prot_q     <= '0;
      mastlock_q <= 1'b0;
      nonsec_q   <= 1'b0;
      excl_q     <= 1'b0;
      master_q   <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      exokay_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q     <= slave_haddr;
        write_q    <= slave_hwrite;
        size_q     <= slave_hsize;
        prot_q     <= slave_hprot;
        mastlock_q <= slave_hmastlock;
        nonsec_q   <= slave_hnonsec;
        excl_q     <= slave_hexcl;
        master_q   <= slave_hmaster;
      end
      // Upstream holds hwdata stable while we stall it, so sampling each ADDR cycle is safe.
      if (state_q == StAddr) wdata_q <= slave_hwdata;
      if (data_ok) begin
        rdata_q  <= master_hrdata;
        exokay_q <= master_hexokay;
      end
    end
  end

  assign slave_hrdata     = rdata_q;
  assign slave_hresp      = (state_q == StErr1) || (state_q == StErr2);
  assign slave_hexokay    = (state_q == StResp) & exokay_q;

  assign master_haddr     = addr_q;
  assign master_htrans    = (state_q == StAddr) ? 2'b10 : 2'b00;
  assign master_hwrite    = write_q;
  assign master_hwdata    = wdata_q;
  assign master_hburst    = 3'b000;
  assign master_hmastlock = mastlock_q;
  assign master_hprot     = prot_q;
  assign master_hsize     = size_q;
  assign master_hnonsec   = nonsec_q;
  assign master_hexcl     = excl_q;
  assign master_hmaster   = master_q;

endmodule
